spi_host: RTL and testbench
===========================

# spi_host

Host-side SPI master that drives the TT6581 register interface. It converts single-register read and write requests from a local controller (test harness, FPGA soft core, or demo sequencer) into 16-bit SPI frames on sclk/cs/mosi. It also returns read data sampled from miso. It is the initiator counterpart of the TT6581 SPI slave and shares the same frame format and clock domain assumptions.

## Interface
Parameters:
- CLK_DIV, 4, sclk half-period in clk_i cycles; legal range is 2 or more, and elaboration fails otherwise. The TT6581 slave oversamples sclk, so production use requires 4 or more.
- CS_GAP, 4, minimum number of clk_i cycles cs_o stays high between frames; legal range is 1 or more.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  high only in IDLE
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  7  register address
- req_wdata_i  in  8  write data; ignored for reads
- rsp_valid_o  out  1  one-cycle pulse at end of every frame
- rsp_rdata_o  out  8  read data; held until the next rsp_valid_o
- busy_o  out  1  high from acceptance until req_ready_o reasserts
- sclk_o  out  1  SPI clock, mode 0, idles low
- cs_o  out  1  chip select, active low
- mosi_o  out  1  serial data out
- miso_i  in  1  serial data in

## Operation
- Frame layout: 16 bits, MSB first. Bit 15 is W (1 = write). Bits 14:8 are the address. Bits 7:0 are data: write data on mosi for writes, read data returned on miso for reads. Mosi carries 0x00 in the data field of a read.
- The request is captured into a 16-bit shift register on the handshake (req_valid_i & req_ready_o).
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE to SETUP on handshake. cs_o goes low and mosi_o presents bit 15.
  - SETUP lasts CLK_DIV cycles with sclk_o low, then moves to SHIFT.
  - SHIFT covers 16 bits. Each bit is sclk_o high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - miso_i is sampled in the cycle sclk_o rises.
    - mosi_o advances to the next bit in the cycle sclk_o falls.
    - After the 16th falling edge the FSM moves to HOLD.
  - HOLD lasts CLK_DIV cycles with cs_o still low, then moves to GAP. cs_o rises and rsp_valid_o pulses.
  - GAP lasts CS_GAP cycles, then returns to IDLE.
- Read data is the last 8 sampled miso bits, MSB first. It updates rsp_rdata_o when rsp_valid_o pulses.
- Write frames also pulse rsp_valid_o. rsp_rdata_o takes the bits sampled during that frame.
- Requests presented while the block is not in IDLE are not accepted. The requester holds them.
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0x00, busy_o=0, sclk_o=0, cs_o=1, mosi_o=0.
- Reset asserted mid-frame abandons the frame immediately: cs_o goes high and sclk_o goes low asynchronously. No rsp_valid_o is generated.

## Timing
- All outputs are registered with no combinational path from input to output. req_ready_o is decoded from the registered state.
- Handshake at cycle T:
  - cs_o is low from T+1 through T+34·CLK_DIV.
  - cs_o rises and rsp_valid_o pulses at T+1+34·CLK_DIV.
  - req_ready_o is high again at T+1+34·CLK_DIV+CS_GAP.
- For CLK_DIV=4 and CS_GAP=4: rsp_valid_o at T+137, ready at T+141.
- Back-to-back requests with req_valid_i held high: the next handshake occurs in the first cycle req_ready_o is high. The frame period is 1+34·CLK_DIV+CS_GAP cycles.
- sclk_o produces exactly 16 rising edges per frame. No sclk edge occurs while cs_o is high.

## Configuration
- SPI_HOST_READBACK_EN
  - Defined: miso sampling and rsp_rdata_o work as described above.
  - Undefined: the miso sampler and read shift path are removed. rsp_rdata_o is tied to 0x00 and miso_i is unused. Read frames are still transmitted, and rsp_valid_o and all frame timing are unchanged.

## Test plan
- Write: W=1, addr 0x18, data 0x0F. Mosi sampled at the sclk rising edges must be 0x980F. rsp_valid_o must pulse once at T+137 (CLK_DIV=4, CS_GAP=4).
- Read: W=0, addr 0x05, with a slave model driving 0xA5 in the data field. Mosi must be 0x0500. rsp_rdata_o must be 0xA5 at rsp_valid_o.
- Back-to-back: three writes with req_valid_i held high. The handshakes must be exactly 141 cycles apart. cs_o must stay high for 4 cycles between frames. There must be 16 sclk edges per frame.
- Reset mid-frame: assert rst_ni low after the 5th sclk rising edge. cs_o must be 1 and sclk_o 0 in the same cycle. No rsp_valid_o may occur. The next write after reset must be transmitted correctly.
- CLK_DIV=2: a write frame must take 1+68 cycles to rsp_valid_o, and each sclk high and low phase must be exactly 2 cycles.
- SPI_HOST_READBACK_EN undefined: a read with miso driven 0xFF must give rsp_rdata_o = 0x00, with rsp_valid_o timing identical to the write case.

Source files
------------

// File: rtl/spi_host.sv
// spi_host: SPI mode-0 host that issues 16-bit TT6581 register frames (W, addr[6:0], data[7:0]).
// Build option: define SPI_HOST_READBACK_EN to keep the miso sampler and rsp_rdata_o path.
//
// state | meaning
// IDLE  | waiting for a request, cs high, req_ready_o high
// SETUP | cs low, bit 15 on mosi, sclk low for CLK_DIV cycles
// SHIFT | 16 sclk periods: sample miso on rise, advance mosi on fall
// HOLD  | sclk low, cs still low for CLK_DIV cycles
// GAP   | cs high for CS_GAP cycles before the next request
module spi_host #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic       req_we_i,
   input  logic [6:0] req_addr_i,
   input  logic [7:0] req_wdata_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_rdata_o,
   output logic       busy_o,
   output logic       sclk_o,
   output logic       cs_o,
   output logic       mosi_o,
   input  logic       miso_i
);

   if (CLK_DIV < 2) begin : g_chk_div
      $error("spi_host: CLK_DIV must be at least 2");
   end
   if (CS_GAP < 1) begin : g_chk_gap
      $error("spi_host: CS_GAP must be at least 1");
   end

   localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(CS_GAP - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       bit_q;
   logic [15:0]      tx_q;
   logic             cnt_done;
   logic             frame_end;

   assign cnt_done    = (cnt_q == '0);
   assign frame_end   = cnt_done && (state_q == ST_HOLD);
   assign req_ready_o = (state_q == ST_IDLE);

   // mosi_o carries the current bit; tx_q holds the remaining bits MSB-first, zero-filled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         tx_q        <= '0;
         sclk_o      <= 1'b0;
         cs_o        <= 1'b1;
         mosi_o      <= 1'b0;
         rsp_valid_o <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         rsp_valid_o <= frame_end;
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  state_q <= ST_SETUP;
                  cnt_q   <= DIV_LD;
                  cs_o    <= 1'b0;
                  busy_o  <= 1'b1;
                  mosi_o  <= req_we_i;
                  tx_q    <= {req_addr_i, (req_we_i ? req_wdata_i : 8'h00), 1'b0};
               end
            end
            ST_SETUP: begin
               if (cnt_done) begin
                  state_q <= ST_SHIFT;
                  cnt_q   <= DIV_LD;
                  sclk_o  <= 1'b1;
                  bit_q   <= 4'd15;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_SHIFT: begin
               if (!cnt_done) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  cnt_q <= DIV_LD;
                  if (sclk_o) begin
                     sclk_o         <= 1'b0;
                     {mosi_o, tx_q} <= {tx_q, 1'b0};
                  end else if (bit_q == 4'd0) begin
                     state_q <= ST_HOLD;
                  end else begin
                     sclk_o <= 1'b1;
                     bit_q  <= bit_q - 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (cnt_done) begin
                  state_q <= ST_GAP;
                  cnt_q   <= GAP_LD;
                  cs_o    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt_done) begin
                  state_q <= ST_IDLE;
                  busy_o  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef SPI_HOST_READBACK_EN
   logic       sclk_rise;
   logic [7:0] rx_q;

   // Same clock edge that drives sclk_o high; miso has been stable since the previous fall.
   assign sclk_rise = cnt_done && ((state_q == ST_SETUP) ||
                      (state_q == ST_SHIFT && !sclk_o && bit_q != 4'd0));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_q        <= '0;
         rsp_rdata_o <= '0;
      end else begin
         if (sclk_rise) rx_q <= {rx_q[6:0], miso_i};
         if (frame_end) rsp_rdata_o <= rx_q;
      end
   end
`else
   logic unused_miso;
   assign unused_miso = miso_i;
   assign rsp_rdata_o = 8'h00;
`endif

endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: directed checks of spi_host frames, timing, back-to-back, reset abort and CLK_DIV=2.
`timescale 1ns/1ps
module tb_spi_host;
   localparam int CD  = 4;
   localparam int GAP = 4;
   localparam int CD2 = 2;
`ifdef SPI_HOST_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic       req_valid, req_ready, req_we;
   logic [6:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       busy, sclk, cs, mosi, miso;

   logic       d2_valid, d2_ready, d2_we;
   logic [6:0] d2_addr;
   logic [7:0] d2_wdata;
   logic       d2_rsp_valid;
   logic [7:0] d2_rdata;
   logic       d2_busy, d2_sclk, d2_cs, d2_mosi;

   spi_host #(.CLK_DIV(CD), .CS_GAP(GAP)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .busy_o(busy),
      .sclk_o(sclk), .cs_o(cs), .mosi_o(mosi), .miso_i(miso)
   );

   spi_host #(.CLK_DIV(CD2), .CS_GAP(GAP)) dut2 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(d2_valid), .req_ready_o(d2_ready), .req_we_i(d2_we),
      .req_addr_i(d2_addr), .req_wdata_i(d2_wdata),
      .rsp_valid_o(d2_rsp_valid), .rsp_rdata_o(d2_rdata), .busy_o(d2_busy),
      .sclk_o(d2_sclk), .cs_o(d2_cs), .mosi_o(d2_mosi), .miso_i(1'b0)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor and slave model for dut, sampled mid-cycle.
   logic        cs_q = 1'b1, sclk_q = 1'b0, rdy_q = 1'b0;
   logic [15:0] slave_word = 16'h0000;
   logic [15:0] s_sr = 16'h0000;
   logic [15:0] f_mosi = 16'h0000;
   int f_rises = 0, low_run = 0, high_run = 0, stray = 0;
   int hs_count = 0, rv_count = 0, rv_cyc = 0, rdy_cyc = 0, fr_n = 0;
   int          hs_cyc[32];
   logic [15:0] fr_mosi[16];
   int          fr_rises[16];
   int          fr_low[16];
   int          gap_before[16];

   assign miso = s_sr[15];

   always @(negedge clk) begin
      cs_q   <= cs;
      sclk_q <= sclk;
      rdy_q  <= req_ready;
      if (req_valid && req_ready) begin
         if (hs_count < 32) hs_cyc[hs_count] <= cyc;
         hs_count <= hs_count + 1;
      end
      if (req_ready && !rdy_q) rdy_cyc <= cyc;
      if (rsp_valid) begin
         rv_count <= rv_count + 1;
         rv_cyc   <= cyc;
      end
      if (!cs) begin
         low_run <= low_run + 1;
         if (cs_q && fr_n < 16) gap_before[fr_n] <= high_run;
         if (sclk && !sclk_q) begin
            f_mosi  <= {f_mosi[14:0], mosi};
            f_rises <= f_rises + 1;
            s_sr    <= {s_sr[14:0], 1'b0};
         end
      end else begin
         if (cs_q && (sclk !== sclk_q)) stray <= stray + 1;
         if (!cs_q && fr_n < 16) begin
            fr_mosi[fr_n]  <= f_mosi;
            fr_rises[fr_n] <= f_rises;
            fr_low[fr_n]   <= low_run;
            fr_n           <= fr_n + 1;
         end
         high_run <= cs_q ? high_run + 1 : 1;
         low_run  <= 0;
         f_rises  <= 0;
         f_mosi   <= 16'h0000;
         s_sr     <= slave_word;
      end
   end

   // Phase-length monitor for dut2.
   logic        d2_cs_q = 1'b1, d2_sclk_q = 1'b0;
   logic [15:0] d2_f_mosi = 16'h0000;
   int d2_run = 0, d2_phases = 0, d2_bad = 0, d2_rises = 0;
   int d2_hs_n = 0, d2_hs_cyc = 0, d2_rv_n = 0, d2_rv_cyc = 0;

   always @(negedge clk) begin
      d2_cs_q   <= d2_cs;
      d2_sclk_q <= d2_sclk;
      if (d2_valid && d2_ready) begin
         d2_hs_cyc <= cyc;
         d2_hs_n   <= d2_hs_n + 1;
      end
      if (d2_rsp_valid) begin
         d2_rv_cyc <= cyc;
         d2_rv_n   <= d2_rv_n + 1;
      end
      if (!d2_cs) begin
         if (d2_cs_q) d2_run <= 1;
         else if (d2_sclk == d2_sclk_q) d2_run <= d2_run + 1;
         else begin
            d2_phases <= d2_phases + 1;
            if (d2_run != CD2) d2_bad <= d2_bad + 1;
            if (d2_sclk) begin
               d2_rises  <= d2_rises + 1;
               d2_f_mosi <= {d2_f_mosi[14:0], d2_mosi};
            end
            d2_run <= 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_hs(input int target, input string tag);
      int i = 0;
      while (hs_count < target && i < 1000) begin
         @(negedge clk); #1;
         i++;
      end
      check(tag, 32'(hs_count >= target), 32'd1);
   endtask

   task automatic wait_rv(input int target, input string tag);
      int i = 0;
      while (rv_count < target && i < 1000) begin
         @(negedge clk); #1;
         i++;
      end
      check(tag, 32'(rv_count >= target), 32'd1);
   endtask

   task automatic wait_idle();
      int i = 0;
      while (!req_ready && i < 1000) begin
         @(negedge clk); #1;
         i++;
      end
      check("ready_timeout", 32'(req_ready), 32'd1);
   endtask

   task automatic send1(input logic we, input logic [6:0] addr, input logic [7:0] wdata);
      int n = hs_count;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      wait_hs(n + 1, "hs_timeout");
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int rv0, hb, fb;
      logic [6:0]  b_addr[3];
      logic [7:0]  b_data[3];
      logic [15:0] b_exp[3];
      b_addr = '{7'h10, 7'h21, 7'h32};
      b_data = '{8'h11, 8'h22, 8'h33};
      b_exp  = '{16'h9011, 16'hA122, 16'hB233};

      rst_n = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      d2_valid = 1'b0; d2_we = 1'b0; d2_addr = '0; d2_wdata = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("reset_outputs", {req_ready, rsp_valid, busy, sclk, cs, mosi, rsp_rdata},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Write 0x18 <- 0x0F; slave returns 0x3C in the data field.
      slave_word = 16'h003C;
      rv0 = rv_count;
      send1(1'b1, 7'h18, 8'h0F);
      check("wr_start", {busy, cs, req_ready, mosi}, 4'b1001);
      wait_rv(rv0 + 1, "wr_rsp_timeout");
      wait_idle();
      check("wr_mosi", fr_mosi[fr_n-1], 16'h980F);
      check("wr_rises", fr_rises[fr_n-1], 16);
      check("wr_cs_low_cycles", fr_low[fr_n-1], 136);
      check("wr_rsp_latency", rv_cyc - hs_cyc[hs_count-1], 137);
      check("wr_ready_latency", rdy_cyc - hs_cyc[hs_count-1], 141);
      check("wr_rsp_pulses", rv_count - rv0, 1);
      check("wr_rdata", rsp_rdata, RB ? 8'h3C : 8'h00);
      check("wr_idle", {busy, cs, sclk}, 3'b010);

      // Read 0x05; wdata must not reach mosi.
      slave_word = 16'h00A5;
      rv0 = rv_count;
      send1(1'b0, 7'h05, 8'hFF);
      check("rd_start", {busy, cs, req_ready, mosi}, 4'b1000);
      wait_rv(rv0 + 1, "rd_rsp_timeout");
      wait_idle();
      check("rd_mosi", fr_mosi[fr_n-1], 16'h0500);
      check("rd_rdata", rsp_rdata, RB ? 8'hA5 : 8'h00);
      check("rd_rsp_latency", rv_cyc - hs_cyc[hs_count-1], 137);

      // Three writes with req_valid held high.
      slave_word = 16'h0000;
      hb = hs_count;
      fb = fr_n;
      rv0 = rv_count;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = b_addr[0]; req_wdata = b_data[0];
      for (int k = 0; k < 3; k++) begin
         wait_hs(hb + k + 1, "b2b_hs_timeout");
         @(posedge clk); #1;
         if (k < 2) begin
            req_addr = b_addr[k+1];
            req_wdata = b_data[k+1];
         end else begin
            req_valid = 1'b0;
         end
      end
      wait_rv(rv0 + 3, "b2b_rsp_timeout");
      wait_idle();
      check("b2b_period_1", hs_cyc[hb+1] - hs_cyc[hb], 141);
      check("b2b_period_2", hs_cyc[hb+2] - hs_cyc[hb+1], 141);
      // High for the GAP cycles plus the IDLE cycle in which the next handshake happens.
      check("b2b_cs_high_1", gap_before[fb+1], GAP + 1);
      check("b2b_cs_high_2", gap_before[fb+2], GAP + 1);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("b2b_mosi_%0d", k), fr_mosi[fb+k], b_exp[k]);
         check($sformatf("b2b_rises_%0d", k), fr_rises[fb+k], 16);
      end
      check("stray_sclk_edges", stray, 0);

      // Reset after the 5th rising sclk edge.
      rv0 = rv_count;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h2A; req_wdata = 8'h55;
      wait_hs(hs_count + 1, "rst_hs_timeout");
      @(posedge clk); #1 req_valid = 1'b0;
      for (int i = 0; i < 200 && f_rises < 5; i++) begin
         @(negedge clk); #1;
      end
      check("rst_pre_state", {f_rises[3:0], cs, sclk}, {4'd5, 1'b0, 1'b1});
      rst_n = 1'b0;
      #1;
      check("rst_async", {cs, sclk, busy, req_ready}, 4'b1001);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      check("rst_no_rsp", rv_count - rv0, 0);

      rv0 = rv_count;
      send1(1'b1, 7'h7F, 8'hA5);
      wait_rv(rv0 + 1, "post_rst_rsp_timeout");
      wait_idle();
      check("post_rst_mosi", fr_mosi[fr_n-1], 16'hFFA5);
      check("post_rst_rises", fr_rises[fr_n-1], 16);
      check("post_rst_latency", rv_cyc - hs_cyc[hs_count-1], 137);

      // CLK_DIV = 2 instance.
      @(posedge clk); #1;
      d2_valid = 1'b1; d2_we = 1'b1; d2_addr = 7'h33; d2_wdata = 8'hC3;
      for (int i = 0; i < 100 && d2_hs_n < 1; i++) begin
         @(negedge clk); #1;
      end
      @(posedge clk); #1 d2_valid = 1'b0;
      for (int i = 0; i < 300 && !(d2_rv_n >= 1 && d2_ready); i++) begin
         @(negedge clk); #1;
      end
      check("d2_rsp_count", d2_rv_n, 1);
      check("d2_rsp_latency", d2_rv_cyc - d2_hs_cyc, 69);
      check("d2_phases", d2_phases, 32);
      check("d2_bad_phases", d2_bad, 0);
      check("d2_rises", d2_rises, 16);
      check("d2_mosi", d2_f_mosi, 16'hB3C3);
      check("d2_idle", {d2_busy, d2_rdata}, 9'h000);

      // Read with miso held high; rdata depends on the readback build option.
      slave_word = 16'hFFFF;
      rv0 = rv_count;
      send1(1'b0, 7'h05, 8'h00);
      wait_rv(rv0 + 1, "rb_rsp_timeout");
      wait_idle();
      check("rb_rdata", rsp_rdata, RB ? 8'hFF : 8'h00);
      check("rb_latency", rv_cyc - hs_cyc[hs_count-1], 137);
      check("rb_mosi", fr_mosi[fr_n-1], 16'h0500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
